// File: rtl/pipe_pkg.sv
// Shared types and encodings for the 16-bit, 4-bit-opcode pipeline.
// The ID/EX register and its hazard logic both import this package.
package pipe_pkg;

    localparam int CTRL_W = 11;

    // Control bundle produced by the decoder, MSB first in this order.
    typedef struct packed {
        logic       regDest;
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic [3:0] aluOp;
    } ctrl_t;

    // Opcodes; 0101, 0110 and 1101-1111 are undefined.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_LHW  = 4'b1000;
    localparam logic [3:0] OP_SHW  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;

    // The decoder forwards the opcode on aluOp, so each ALU encoding
    // equals its opcode and an undefined opcode arrives there verbatim.
    localparam logic [3:0] ALUOP_ADD  = OP_ADD;
    localparam logic [3:0] ALUOP_SUB  = OP_SUB;
    localparam logic [3:0] ALUOP_AND  = OP_AND;
    localparam logic [3:0] ALUOP_OR   = OP_OR;
    localparam logic [3:0] ALUOP_SLT  = OP_SLT;
    localparam logic [3:0] ALUOP_ADDI = OP_ADDI;
    localparam logic [3:0] ALUOP_LHW  = OP_LHW;
    localparam logic [3:0] ALUOP_SHW  = OP_SHW;
    localparam logic [3:0] ALUOP_BEQ  = OP_BEQ;
    localparam logic [3:0] ALUOP_BNE  = OP_BNE;
    localparam logic [3:0] ALUOP_JMP  = OP_JMP;

    // True when the opcode seen on aluOp is one the decoder defines.
    function automatic logic isDefinedOp(input logic [3:0] op);
        logic defined;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
            OP_LHW, OP_SHW, OP_BEQ, OP_BNE, OP_JMP: defined = 1'b1;
            default:                                defined = 1'b0;
        endcase
        return defined;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// register a load currently in EX has not yet returned.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RADDR_W = 4
) (
    input  logic               id_valid,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               ex_valid,
    input  logic [CTRL_W-1:0]  ex_ctrl,
    input  logic [RADDR_W-1:0] ex_dest,
    output logic               lu
);

    ctrl_t idC;
    ctrl_t exC;
    logic  usesRt;
    logic  unusedBits;

    assign idC = ctrl_t'(id_ctrl);
    assign exC = ctrl_t'(ex_ctrl);

    // Only a handful of control bits matter for the hazard decision.
    assign unusedBits = &{1'b0, idC.regDest, idC.memRead, idC.memToReg,
                          idC.regWrite, idC.aluOp, exC.regDest, exC.branch,
                          exC.memToReg, exC.memWrite, exC.aluSrc,
                          exC.regWrite, exC.aluOp};

    // rt is a source for R-type, store data and branch compares.
    always_comb begin
        usesRt = !idC.aluSrc | idC.memWrite | idC.branch;
        lu     = id_valid & ex_valid & exC.memRead & (ex_dest != '0)
               & ((ex_dest == id_rs) | (usesRt & (ex_dest == id_rt)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder control and operands,
// inserts one bubble per load-use pair, and honours hold and flush.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               ex_hold,
    input  logic               flush,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_dest,
    output logic               stall_up,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t              idCtrl;
    ctrl_t              capCtrl;
    logic               capValid;
    logic [RADDR_W-1:0] capDest;
    logic               loadUse;

    assign idCtrl = ctrl_t'(id_ctrl);

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) uHazard (
        .id_valid (id_valid),
        .id_ctrl  (id_ctrl),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .ex_valid (ex_valid),
        .ex_ctrl  (ex_ctrl),
        .ex_dest  (ex_dest),
        .lu       (loadUse)
    );

    // Upstream must hold while EX is blocked or a bubble is being
    // inserted; a flush discards the ID instruction so nothing waits.
    always_comb begin
        stall_up = !flush & (ex_hold | loadUse);
    end

    // Scrub the decoder bundle before capture: bits the decoder may
    // leave undefined are forced low, and undefined opcodes or empty
    // slots become a clean bubble with no write-back register.
    always_comb begin
        capCtrl  = idCtrl;
        capValid = id_valid & isDefinedOp(idCtrl.aluOp);
        if (!idCtrl.regWrite) begin
            capCtrl.regDest  = 1'b0;
            capCtrl.memToReg = 1'b0;
        end
        if (!capValid) begin
            capCtrl = '0;
        end
        capDest = '0;
        if (capCtrl.regWrite) begin
            capDest = capCtrl.regDest ? id_rd : id_rt;
        end
    end

    // Pipeline register: flush beats hold beats bubble beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_dest  <= '0;
        end else if (ex_hold) begin
            ex_valid <= ex_valid;
        end else if (loadUse) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_dest  <= '0;
        end else begin
            ex_valid   <= capValid;
            ex_ctrl    <= capCtrl;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_dest    <= capDest;
        end
    end

    // Count inserted load-use bubbles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush && !ex_hold && loadUse && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage with a behavioural
// model of the ID/EX register; a narrow counter exercises saturation.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               id_valid = 1'b0;
    logic [10:0]        id_ctrl = '0;
    logic [DATA_W-1:0]  id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc = '0;
    logic [RADDR_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic               ex_hold = 1'b0, flush = 1'b0;
    logic               ex_valid;
    logic [10:0]        ex_ctrl;
    logic [DATA_W-1:0]  ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic [RADDR_W-1:0] ex_rs, ex_rt, ex_dest;
    logic               stall_up;
    logic [CNT_W-1:0]   bubble_cnt;

    int nChecks = 0;
    int nPass = 0;

    // Model state: what the EX slot must contain.
    logic               mValid = 1'b0;
    logic [10:0]        mCtrl = '0;
    logic [DATA_W-1:0]  mRsData = '0, mRtData = '0, mImm = '0, mPc = '0;
    logic [RADDR_W-1:0] mRs = '0, mRt = '0, mDest = '0;
    logic [CNT_W-1:0]   mCnt = '0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_hold(ex_hold), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .stall_up(stall_up), .bubble_cnt(bubble_cnt)
    );

    function automatic logic isUndef(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op >= 4'd13);
    endfunction

    // Decoder behaviour: bit order regDest,branch,memRead,memToReg,memWrite,aluSrc,regWrite.
    function automatic logic [10:0] makeCtrl(input logic [3:0] op);
        logic [6:0] b;
        logic       junkA, junkB;
        junkA = 1'($urandom_range(1, 0));
        junkB = 1'($urandom_range(1, 0));
        if (op <= 4'd4)                       b = 7'b1000001;
        else if (op == OP_ADDI)               b = 7'b0000011;
        else if (op == OP_LHW)                b = 7'b0011011;
        else if (op == OP_SHW)                b = {junkA, 2'b00, junkB, 3'b110};
        else if (op == OP_BEQ || op == OP_BNE) b = {junkA, 2'b10, junkB, 3'b000};
        else if (op == OP_JMP)                b = {junkA, 2'b10, junkB, 3'b010};
        else                                  b = 7'($urandom_range(127, 0));
        return {b, op};
    endfunction

    function automatic logic modelLu();
        logic usesRt;
        usesRt = !id_ctrl[5] || id_ctrl[6] || id_ctrl[9];
        return id_valid && mValid && mCtrl[8] && (mDest != 0)
            && ((mDest == id_rs) || (usesRt && (mDest == id_rt)));
    endfunction

    function automatic logic [10:0] scrubCtrl(input logic [10:0] c);
        logic [10:0] r;
        r = c;
        if (!r[4]) begin
            r[10] = 1'b0;
            r[7]  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] destOf(input logic [10:0] c, input logic [3:0] rt, input logic [3:0] rd);
        if (!c[4]) return 4'd0;
        return c[10] ? rd : rt;
    endfunction

    // Behavioural reference for the EX slot and bubble counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid <= 1'b0; mCtrl <= '0; mDest <= '0; mCnt <= '0;
            mRsData <= '0; mRtData <= '0; mImm <= '0; mPc <= '0; mRs <= '0; mRt <= '0;
        end else if (flush) begin
            mValid <= 1'b0; mCtrl <= '0; mDest <= '0;
        end else if (ex_hold) begin
            mValid <= mValid;
        end else if (modelLu()) begin
            mValid <= 1'b0; mCtrl <= '0; mDest <= '0;
            mCnt <= (mCnt == 3'd7) ? mCnt : mCnt + 3'd1;
        end else begin
            mRsData <= id_rs_data; mRtData <= id_rt_data; mImm <= id_imm; mPc <= id_pc;
            mRs <= id_rs; mRt <= id_rt;
            if (!id_valid || isUndef(id_ctrl[3:0])) begin
                mValid <= 1'b0; mCtrl <= '0; mDest <= '0;
            end else begin
                mValid <= 1'b1;
                mCtrl  <= scrubCtrl(id_ctrl);
                mDest  <= destOf(scrubCtrl(id_ctrl), id_rt, id_rd);
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput();
        checkVal("ex_valid", 32'(ex_valid), 32'(mValid));
        checkVal("ex_ctrl", 32'(ex_ctrl), 32'(mCtrl));
        checkVal("ex_dest", 32'(ex_dest), 32'(mDest));
        checkVal("bubble_cnt", 32'(bubble_cnt), 32'(mCnt));
        if (mValid) begin
            checkVal("ex_rs_data", 32'(ex_rs_data), 32'(mRsData));
            checkVal("ex_rt_data", 32'(ex_rt_data), 32'(mRtData));
            checkVal("ex_imm", 32'(ex_imm), 32'(mImm));
            checkVal("ex_pc", 32'(ex_pc), 32'(mPc));
            checkVal("ex_rs", 32'(ex_rs), 32'(mRs));
            checkVal("ex_rt", 32'(ex_rt), 32'(mRt));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] rs,
                                 input logic [3:0] rt, input logic [3:0] rd, input logic [15:0] pc);
        id_valid   = v;
        id_ctrl    = makeCtrl(op);
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_pc      = pc;
        id_rs_data = 16'($urandom);
        id_rt_data = 16'($urandom);
        id_imm     = 16'($urandom);
        ex_hold    = 1'b0;
        flush      = 1'b0;
    endtask

    // One clock: check stall_up against current inputs, then the EX slot after the edge.
    task automatic cycle();
        #1;
        checkVal("stall_up", 32'(stall_up), 32'(!flush && (ex_hold || modelLu())));
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(($urandom_range(9, 0) != 0), 4'($urandom_range(15, 0)),
                          4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
                          4'($urandom_range(3, 0)), 16'($urandom));
            ex_hold = ($urandom_range(7, 0) == 0);
            flush   = ($urandom_range(9, 0) == 0);
            cycle();
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        randomCycles(200);

        // Reset mid-stream.
        rst_n = 1'b0; id_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0;
        #1;
        checkVal("rst_valid", 32'(ex_valid), 32'd0);
        checkVal("rst_ctrl", 32'(ex_ctrl), 32'd0);
        checkVal("rst_cnt", 32'(bubble_cnt), 32'd0);
        checkVal("rst_pc", 32'(ex_pc), 32'd0);
        checkVal("rst_stall", 32'(stall_up), 32'd0);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, OP_ADD, 0, 0, 0, 16'h0);
        cycle();

        // Load-use: lhw r3 then add r5 = r3 + r2.
        applyStimulus(1'b1, OP_LHW, 4'd1, 4'd3, 4'd0, 16'h0010);
        cycle();
        checkVal("lu_load_dest", 32'(ex_dest), 32'd3);
        applyStimulus(1'b1, OP_ADD, 4'd3, 4'd2, 4'd5, 16'h0012);
        #1 checkVal("lu_stall", 32'(stall_up), 32'd1);
        cycle();
        checkVal("lu_bubble_valid", 32'(ex_valid), 32'd0);
        checkVal("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
        #1 checkVal("lu_stall_gone", 32'(stall_up), 32'd0);
        cycle();
        checkVal("lu_add_valid", 32'(ex_valid), 32'd1);
        checkVal("lu_add_dest", 32'(ex_dest), 32'd5);

        // No false hazards.
        applyStimulus(1'b1, OP_LHW, 4'd1, 4'd0, 4'd0, 16'h0020);
        cycle();
        applyStimulus(1'b1, OP_ADD, 4'd0, 4'd1, 4'd4, 16'h0022);
        #1 checkVal("nohaz_r0", 32'(stall_up), 32'd0);
        cycle();
        applyStimulus(1'b1, OP_LHW, 4'd1, 4'd3, 4'd0, 16'h0024);
        cycle();
        applyStimulus(1'b1, OP_ADDI, 4'd1, 4'd3, 4'd0, 16'h0026);
        #1 checkVal("nohaz_addi_rt", 32'(stall_up), 32'd0);
        cycle();
        applyStimulus(1'b1, OP_ADD, 4'd3, 4'd1, 4'd6, 16'h0028);
        #1 checkVal("nohaz_nonload", 32'(stall_up), 32'd0);
        cycle();

        // Flush beats hold.
        applyStimulus(1'b1, OP_ADDI, 4'd1, 4'd2, 4'd0, 16'h0030);
        ex_hold = 1'b1;
        flush   = 1'b1;
        #1 checkVal("flush_stall", 32'(stall_up), 32'd0);
        cycle();
        checkVal("flush_valid", 32'(ex_valid), 32'd0);
        checkVal("flush_ctrl", 32'(ex_ctrl), 32'd0);

        // Hold for three cycles with changing ID, then release.
        applyStimulus(1'b1, OP_ADDI, 4'd1, 4'd2, 4'd0, 16'hA5A5);
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 16'($urandom));
            ex_hold = 1'b1;
            cycle();
            checkVal("hold_pc", 32'(ex_pc), 32'hA5A5);
        end
        applyStimulus(1'b1, OP_SUB, 4'd1, 4'd2, 4'd3, 16'h1234);
        cycle();
        checkVal("release_pc", 32'(ex_pc), 32'h1234);

        // X scrub: branch and undefined opcode.
        applyStimulus(1'b1, OP_BEQ, 4'd1, 4'd2, 4'd3, 16'h0040);
        id_ctrl[10] = 1'b1;
        id_ctrl[7]  = 1'b1;
        cycle();
        checkVal("beq_dest", 32'(ex_dest), 32'd0);
        checkVal("beq_scrub", 32'({ex_ctrl[10], ex_ctrl[7]}), 32'd0);
        applyStimulus(1'b1, 4'b1110, 4'd1, 4'd2, 4'd3, 16'h0042);
        cycle();
        checkVal("undef_valid", 32'(ex_valid), 32'd0);
        checkVal("undef_ctrl", 32'(ex_ctrl), 32'd0);

        randomCycles(300);

        // Saturation of the narrow bubble counter.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, OP_LHW, 4'd1, 4'd3, 4'd0, 16'h0050);
            cycle();
            applyStimulus(1'b1, OP_ADD, 4'd3, 4'd2, 4'd5, 16'h0052);
            cycle();
            cycle();
        end
        checkVal("sat_full", 32'(bubble_cnt), 32'd7);
        applyStimulus(1'b1, OP_LHW, 4'd1, 4'd3, 4'd0, 16'h0060);
        cycle();
        applyStimulus(1'b1, OP_ADD, 4'd3, 4'd2, 4'd5, 16'h0062);
        #1 checkVal("sat_lu", 32'(stall_up), 32'd1);
        cycle();
        checkVal("sat_stay", 32'(bubble_cnt), 32'd7);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
